nfca_picc_tx: RTL

//  NFC-A (ISO14443A) PICC-to-PCD transmitter for card-emulation builds: converts an axis-like byte stream

---
 rtl/nfca_picc_tx.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/nfca_picc_tx.sv
`timescale 1ns/1ps
// nfca_picc_tx
// NFC-A (ISO14443A) PICC-to-PCD transmitter for card emulation. Byte stream in,
// Manchester-coded 847.5 kHz subcarrier load modulation out, framed as
// SOF, data bits (LSB first) with odd parity per full byte, then EOF.
//
// Ports
//   clk          81.36 MHz clock
//   rstn         asynchronous active-low reset
//   tx_tvalid    byte valid
//   tx_tready    byte accepted when tx_tvalid & tx_tready
//   tx_tdata     byte, sent LSB first
//   tx_tdatab    valid bits of the last byte (1..8, 0 or >8 means 8), only with tx_tlast
//   tx_tlast     last byte of the frame
//   tx_busy      high from SOF through EOF
//   tx_done      one-cycle pulse on the final EOF cycle
//   tx_underrun  one-cycle pulse on the first EOF cycle of a frame cut short
//   mod_out      load-modulation switch control, 1 = load on
module nfca_picc_tx #(
  parameter int SUBC_HALF = 48,
  parameter int SUBC_NUM  = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_tvalid,
  output logic       tx_tready,
  input  logic [7:0] tx_tdata,
  input  logic [3:0] tx_tdatab,
  input  logic       tx_tlast,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun,
  output logic       mod_out
);

  localparam int PH_W = (SUBC_HALF > 1) ? $clog2(SUBC_HALF) : 1;
  localparam int HP_W = $clog2(2 * SUBC_NUM);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SUBC_HALF - 1);
  localparam logic [HP_W-1:0] HP_LAST = HP_W'(2 * SUBC_NUM - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SOF  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_PAR  = 3'd3;
  localparam logic [2:0] S_EOF  = 3'd4;

  // Bit count of a byte: only a tlast byte may be partial.
  function automatic logic [3:0] norm_len(input logic [3:0] db, input logic last);
    if (last && (db >= 4'd1) && (db <= 4'd7)) return db;
    return 4'd8;
  endfunction

  function automatic logic odd_par(input logic [7:0] b);
    return ~(^b);
  endfunction

  // Control state
  logic [2:0]      state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic            half_q, half_d;
  logic            bit_q, bit_d;
  logic [2:0]      idx_q, idx_d;
  logic            buf_full_q, buf_full_d;
  logic            urun_q, urun_d;
  logic            mod_q, mod_d;
  // Data path (no reset needed)
  logic [7:0]      byte_q, byte_d;
  logic [3:0]      len_q, len_d;
  logic            last_q, last_d;
  logic [7:0]      buf_data_q, buf_data_d;
  logic [3:0]      buf_len_q, buf_len_d;
  logic            buf_last_q, buf_last_d;

  logic accept;
  logic bit_end;
  logic load;

  assign tx_tready   = ~buf_full_q & (state_q != S_EOF);
  assign accept      = tx_tvalid & tx_tready;
  assign bit_end     = (ph_q == PH_LAST) & (hp_q == HP_LAST) & half_q;
  assign tx_busy     = (state_q != S_IDLE);
  assign tx_done     = (state_q == S_EOF) & bit_end;
  assign tx_underrun = urun_q;
  assign mod_out     = mod_q;

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    hp_d       = hp_q;
    half_d     = half_q;
    bit_d      = bit_q;
    idx_d      = idx_q;
    buf_full_d = buf_full_q;
    urun_d     = 1'b0;
    byte_d     = byte_q;
    len_d      = len_q;
    last_d     = last_q;
    buf_data_d = buf_data_q;
    buf_len_d  = buf_len_q;
    buf_last_d = buf_last_q;
    load       = 1'b0;

    if (accept) begin
      buf_full_d = 1'b1;
      buf_data_d = tx_tdata;
      buf_len_d  = norm_len(tx_tdatab, tx_tlast);
      buf_last_d = tx_tlast;
    end

    // Timing chain runs only inside a frame and wraps to zero exactly at
    // each bit boundary, so IDLE always restarts from a clean phase.
    if (state_q != S_IDLE) begin
      if (ph_q == PH_LAST) begin
        ph_d = '0;
        if (hp_q == HP_LAST) begin
          hp_d   = '0;
          half_d = ~half_q;
        end else begin
          hp_d = hp_q + 1'b1;
        end
      end else begin
        ph_d = ph_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        // Start the cycle after the buffer fills, whether it filled just
        // now or was preloaded during the previous frame.
        if (buf_full_q || accept) begin
          state_d = S_SOF;
          bit_d   = 1'b1;
        end
      end
      S_SOF: begin
        if (bit_end) load = 1'b1;
      end
      S_DATA: begin
        if (bit_end) begin
          if ({1'b0, idx_q} != (len_q - 4'd1)) begin
            idx_d = idx_q + 3'd1;
            bit_d = byte_q[idx_q + 3'd1];
          end else if (len_q == 4'd8) begin
            state_d = S_PAR;
            bit_d   = odd_par(byte_q);
          end else begin
            state_d = S_EOF;
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          if (last_q) begin
            state_d = S_EOF;
          end else if (buf_full_q) begin
            load = 1'b1;
          end else begin
            state_d = S_EOF;
            urun_d  = 1'b1;
          end
        end
      end
      S_EOF: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Moving the byte into the shifter frees the buffer on the first
    // cycle of its first bit, so the next byte can be preloaded.
    if (load) begin
      state_d    = S_DATA;
      byte_d     = buf_data_q;
      len_d      = buf_len_q;
      last_d     = buf_last_q;
      idx_d      = 3'd0;
      bit_d      = buf_data_q[0];
      buf_full_d = 1'b0;
    end
  end

  // Manchester: logic 1 modulates the first half, logic 0 the second.
  // A modulated half is SUBC_NUM subcarrier periods, each starting high.
  always_comb begin
    mod_d = ((state_d == S_SOF) || (state_d == S_DATA) || (state_d == S_PAR)) &&
            (half_d ^ bit_d) && !hp_d[0];
  end

  // Stage boundary: control registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      hp_q       <= '0;
      half_q     <= 1'b0;
      bit_q      <= 1'b0;
      idx_q      <= 3'd0;
      buf_full_q <= 1'b0;
      urun_q     <= 1'b0;
      mod_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      hp_q       <= hp_d;
      half_q     <= half_d;
      bit_q      <= bit_d;
      idx_q      <= idx_d;
      buf_full_q <= buf_full_d;
      urun_q     <= urun_d;
      mod_q      <= mod_d;
    end
  end

  // Stage boundary: data registers
  always_ff @(posedge clk) begin
    byte_q     <= byte_d;
    len_q      <= len_d;
    last_q     <= last_d;
    buf_data_q <= buf_data_d;
    buf_len_q  <= buf_len_d;
    buf_last_q <= buf_last_d;
  end

endmodule
